// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stages: FSM state encoding and
// default payload widths used at the core's stage boundaries.
package pipe_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_CTRL_W = 3;

endpackage

// File: rtl/pipe_skid_entry.sv
// One register slice of the skid buffer: a valid bit plus datapath and control
// payload, with flush clear, load and release controls.
module pipe_skid_entry
  import pipe_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int CTRL_W   = DEF_CTRL_W,
  parameter bit CLR_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic              drop,
  input  logic [DATA_W-1:0] d_data,
  input  logic [CTRL_W-1:0] d_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  // Clear outranks load so a flush discards a same-cycle capture; drop only
  // releases the slot and leaves the payload untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      data  <= '0;
      ctrl  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
      if (CLR_DATA) data <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= d_data;
      ctrl  <= d_ctrl;
    end else if (drop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline stage built from a main and a skid register slice; the
// main slice always drives the outputs and the skid slice absorbs backpressure.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int CTRL_W   = DEF_CTRL_W,
  parameter bit CLR_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [1:0]        o_occ
);

  logic [1:0]        state, state_nxt;
  logic              in_xfer, out_xfer;
  logic              main_load, main_drop, skid_load, skid_drop;
  logic              main_valid, skid_valid;
  logic [DATA_W-1:0] main_data, skid_data, main_d_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_d_ctrl;

  assign in_xfer  = i_valid & o_ready;
  assign out_xfer = o_valid & i_ready;

  always_comb begin
    state_nxt = state;
    main_load = 1'b0;
    main_drop = 1'b0;
    skid_load = 1'b0;
    skid_drop = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (in_xfer) begin
          state_nxt = ST_BUSY;
          main_load = 1'b1;
        end
      end
      ST_BUSY: begin
        if (in_xfer && !out_xfer) begin
          state_nxt = ST_FULL;
          skid_load = 1'b1;
        end else if (in_xfer && out_xfer) begin
          main_load = 1'b1;
        end else if (out_xfer) begin
          state_nxt = ST_EMPTY;
          main_drop = 1'b1;
        end
      end
      ST_FULL: begin
        if (out_xfer) begin
          state_nxt = ST_BUSY;
          main_load = 1'b1;
          skid_drop = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
    if (i_flush) state_nxt = ST_EMPTY;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_EMPTY;
    else      state <= state_nxt;
  end

  // Draining a full stage refills main from skid; otherwise main takes the input.
  assign main_d_data = (state == ST_FULL) ? skid_data : i_data;
  assign main_d_ctrl = (state == ST_FULL) ? skid_ctrl : i_ctrl;

  pipe_skid_entry #(
    .DATA_W  (DATA_W),
    .CTRL_W  (CTRL_W),
    .CLR_DATA(CLR_DATA)
  ) u_main (
    .clk   (clk),
    .rst   (rst),
    .clear (i_flush),
    .load  (main_load),
    .drop  (main_drop),
    .d_data(main_d_data),
    .d_ctrl(main_d_ctrl),
    .valid (main_valid),
    .data  (main_data),
    .ctrl  (main_ctrl)
  );

  pipe_skid_entry #(
    .DATA_W  (DATA_W),
    .CTRL_W  (CTRL_W),
    .CLR_DATA(CLR_DATA)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .clear (i_flush),
    .load  (skid_load),
    .drop  (skid_drop),
    .d_data(i_data),
    .d_ctrl(i_ctrl),
    .valid (skid_valid),
    .data  (skid_data),
    .ctrl  (skid_ctrl)
  );

  // Both handshake outputs come straight from slice valid flops, so o_ready
  // never sees i_ready combinationally.
  assign o_valid = main_valid;
  assign o_ready = ~skid_valid;
  assign o_data  = main_data;
  assign o_ctrl  = main_valid ? main_ctrl : '0;
  assign o_occ   = state;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench for pipe_skid_stage: accepted words are queued as the
// reference FIFO and a negedge monitor checks every presented output against it.
module tb_pipe_skid_stage;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  ctrl;
  } item_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_flush = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] i_data = '0;
  logic [2:0]  i_ctrl = '0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [31:0] o_data;
  logic [2:0]  o_ctrl;
  logic [1:0]  o_occ;

  item_t q[$];
  item_t pend_item;
  bit    pend = 1'b0;
  int    checks = 0;
  int    errors = 0;

  pipe_skid_stage dut (
    .clk    (clk),
    .rst    (rst),
    .i_flush(i_flush),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_data (i_data),
    .i_ctrl (i_ctrl),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_data (o_data),
    .o_ctrl (o_ctrl),
    .o_occ  (o_occ)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of upstream/downstream drive; a word offered this cycle joins the
  // reference FIFO at the edge that captures it.
  task automatic applyStimulus(input bit v, input logic [31:0] d, input logic [2:0] c,
                               input bit rdy, input bit fl);
    @(posedge clk);
    if (pend) begin
      q.push_back(pend_item);
      pend = 1'b0;
    end
    #1;
    i_valid = v;
    i_data  = d;
    i_ctrl  = c;
    i_ready = rdy;
    i_flush = fl;
    if (v && o_ready && !fl) begin
      pend      = 1'b1;
      pend_item = '{data: d, ctrl: c};
    end
  endtask

  task automatic applyReset();
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_flush = 1'b0;
    rst     = 1'b0;
    #1;
    checkOutput("rst_valid", {31'd0, o_valid}, 32'd0);
    checkOutput("rst_ready", {31'd0, o_ready}, 32'd1);
    checkOutput("rst_occ",   {30'd0, o_occ},   32'd0);
    checkOutput("rst_ctrl",  {29'd0, o_ctrl},  32'd0);
    pend = 1'b0;
    q.delete();
    #1;
    rst = 1'b1;
  endtask

  // Reference checks: occupancy equals FIFO depth, the head word is what the
  // stage presents, and a consumed or flushed word leaves the FIFO.
  always @(negedge clk) begin
    if (rst) begin
      checkOutput("occ",   {30'd0, o_occ},   q.size());
      checkOutput("valid", {31'd0, o_valid}, {31'd0, q.size() != 0});
      checkOutput("ready", {31'd0, o_ready}, {31'd0, q.size() < 2});
      if (o_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_output: got 0x%0h, expected no word at %0t", o_data, $time);
        end else begin
          checkOutput("data", o_data, q[0].data);
          checkOutput("ctrl", {29'd0, o_ctrl}, {29'd0, q[0].ctrl});
          if (i_ready) void'(q.pop_front());
        end
      end else begin
        checkOutput("bubble_ctrl", {29'd0, o_ctrl}, 32'd0);
      end
      if (i_flush) q.delete();
    end
  end

  initial begin
    #23;
    checkOutput("init_valid", {31'd0, o_valid}, 32'd0);
    checkOutput("init_ready", {31'd0, o_ready}, 32'd1);
    checkOutput("init_occ",   {30'd0, o_occ},   32'd0);
    checkOutput("init_data",  o_data,           32'd0);
    rst = 1'b1;

    $display("[TB] stream");
    applyStimulus(1, 32'h11, 3'd1, 1, 0);
    applyStimulus(1, 32'h22, 3'd2, 1, 0);
    checkOutput("stream_lat", o_data, 32'h11);
    applyStimulus(1, 32'h33, 3'd3, 1, 0);
    checkOutput("stream_2", o_data, 32'h22);
    applyStimulus(0, 32'h0, 3'd0, 1, 0);
    checkOutput("stream_3", o_data, 32'h33);
    applyStimulus(0, 32'h0, 3'd0, 1, 0);

    $display("[TB] stall");
    applyStimulus(1, 32'hA, 3'd1, 0, 0);
    applyStimulus(1, 32'hB, 3'd2, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 32'h0, 3'd0, 0, 0);
    checkOutput("stall_occ",   {30'd0, o_occ},   32'd2);
    checkOutput("stall_ready", {31'd0, o_ready}, 32'd0);
    checkOutput("stall_data",  o_data,           32'hA);
    applyStimulus(0, 32'h0, 3'd0, 1, 0);
    applyStimulus(0, 32'h0, 3'd0, 1, 0);
    checkOutput("release_b", o_data, 32'hB);
    applyStimulus(0, 32'h0, 3'd0, 1, 0);

    $display("[TB] flush");
    applyStimulus(1, 32'h1, 3'b101, 0, 0);
    applyStimulus(1, 32'h2, 3'b101, 0, 0);
    applyStimulus(0, 32'h0, 3'd0, 0, 0);
    applyStimulus(1, 32'hC, 3'b101, 0, 1);
    applyStimulus(0, 32'h0, 3'd0, 1, 0);
    checkOutput("flush_valid", {31'd0, o_valid}, 32'd0);
    checkOutput("flush_ctrl",  {29'd0, o_ctrl},  32'd0);
    checkOutput("flush_occ",   {30'd0, o_occ},   32'd0);
    checkOutput("flush_data",  o_data,           32'd0);
    applyStimulus(1, 32'h3, 3'd4, 0, 0);
    applyStimulus(1, 32'hD, 3'd6, 0, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 32'h0, 3'd0, 1, 0);
    checkOutput("flush_busy_occ", {30'd0, o_occ}, 32'd0);

    $display("[TB] bubble");
    for (int i = 0; i < 3; i++) applyStimulus(0, 32'hFFFF, 3'b111, 1, 0);
    checkOutput("bubble_occ",  {30'd0, o_occ},  32'd0);
    checkOutput("bubble_ctrl", {29'd0, o_ctrl}, 32'd0);

    $display("[TB] reset mid-run");
    applyStimulus(1, 32'h55, 3'd5, 0, 0);
    applyStimulus(1, 32'h66, 3'd6, 0, 0);
    applyStimulus(0, 32'h0, 3'd0, 0, 0);
    checkOutput("pre_rst_occ", {30'd0, o_occ}, 32'd2);
    applyReset();
    applyStimulus(0, 32'h0, 3'd0, 1, 0);

    $display("[TB] random");
    for (int i = 0; i < 10000; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom, 3'($urandom_range(0, 7)),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
    end
    for (int i = 0; i < 6; i++) applyStimulus(0, 32'h0, 3'd0, 1, 0);
    checkOutput("drain_empty", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
